// File: rtl/logicnet_layer_seq_if.sv
// Configuration, stream handshake and status bundle for logicnet_layer_seq.
// The slave modport is the sequencer side; the master modport is the surrounding pipeline.
interface logicnet_layer_seq_if #(
  parameter int IN_ACTS = 16,
  parameter int IN_BW   = 2,
  parameter int NEURONS = 8,
  parameter int OUT_BW  = 2
);
  logic                        cfg_we;
  logic                        cfg_sel;
  logic [15:0]                 cfg_addr;
  logic [15:0]                 cfg_wdata;
  logic                        cfg_err;
  logic                        s_valid;
  logic                        s_ready;
  logic [IN_ACTS*IN_BW-1:0]    s_data;
  logic                        m_valid;
  logic                        m_ready;
  logic [NEURONS*OUT_BW-1:0]   m_data;
  logic                        busy;
  logic [15:0]                 perf_frames;
  logic [15:0]                 perf_stall;

  modport master (
    output cfg_we, cfg_sel, cfg_addr, cfg_wdata, s_valid, s_data, m_ready,
    input  cfg_err, s_ready, m_valid, m_data, busy, perf_frames, perf_stall
  );

  modport slave (
    input  cfg_we, cfg_sel, cfg_addr, cfg_wdata, s_valid, s_data, m_ready,
    output cfg_err, s_ready, m_valid, m_data, busy, perf_frames, perf_stall
  );
endinterface

// File: rtl/logicnet_layer_seq.sv
// Time-multiplexed evaluator for one sparse LogicNet layer: one neuron per FETCH/LOOK/STORE pass.
// Define LOGICNET_LAYER_SEQ_PERF_EN to build the saturating frame and stall counters.
module logicnet_layer_seq #(
  parameter int IN_ACTS = 16,
  parameter int IN_BW   = 2,
  parameter int FANIN   = 3,
  parameter int NEURONS = 8,
  parameter int OUT_BW  = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  logicnet_layer_seq_if.slave io
);
  localparam int TA    = FANIN * IN_BW;
  localparam int IW    = (IN_ACTS > 1) ? $clog2(IN_ACTS) : 1;
  localparam int NW    = (NEURONS > 1) ? $clog2(NEURONS) : 1;
  localparam int SW    = (FANIN > 1) ? $clog2(FANIN) : 1;
  localparam int DEPTH = NEURONS * (2 ** TA);

  typedef enum logic [2:0] {IDLE, FETCH, LOOK, STORE, OUT} state_t;

  state_t                      state;
  logic [NW-1:0]               n;
  logic                        s_ready_r;
  logic                        m_valid_r;
  logic                        busy_r;
  logic                        cfg_err_r;
  logic [NEURONS*OUT_BW-1:0]   m_data_r;

  // Truth tables addressed {neuron, entry}; connectivity keeps an out-of-range flag above the index.
  logic [OUT_BW-1:0]           tbl_mem  [DEPTH];
  logic [IW:0]                 conn_mem [NEURONS][FANIN];

  logic [IN_ACTS*IN_BW-1:0]    in_reg;
  logic [IW:0]                 conn_rd_p0 [FANIN];
  logic [OUT_BW-1:0]           tbl_rd_p1;
  logic [TA-1:0]               look_addr;

  logic [15:0]                 tbl_nrn;
  logic [TA-1:0]               tbl_ent;
  logic [15:0]                 conn_nrn;
  logic [SW-1:0]               conn_slot;
  logic                        conn_oor;
  logic                        cfg_in_range;
  logic                        cfg_go;
  logic                        accept;

  assign tbl_nrn   = io.cfg_addr >> TA;
  assign tbl_ent   = io.cfg_addr[TA-1:0];
  assign conn_nrn  = io.cfg_addr >> SW;
  assign conn_slot = io.cfg_addr[SW-1:0];
  assign conn_oor  = (io.cfg_wdata >= 16'(IN_ACTS));

  assign cfg_in_range = io.cfg_sel ? ((conn_nrn < 16'(NEURONS)) && (32'(conn_slot) < FANIN))
                                   : (tbl_nrn < 16'(NEURONS));
  assign cfg_go = io.cfg_we && (state == IDLE) && cfg_in_range;
  assign accept = (state == IDLE) && io.s_valid;

  always_ff @(posedge clk) begin
    if (cfg_go && !io.cfg_sel)
      tbl_mem[{tbl_nrn[NW-1:0], tbl_ent}] <= io.cfg_wdata[OUT_BW-1:0];
    if (cfg_go && io.cfg_sel)
      conn_mem[conn_nrn[NW-1:0]][conn_slot] <= {conn_oor, io.cfg_wdata[IW-1:0]};
  end

  // Slot 0 lands in the address MSBs; a flagged index contributes a zero activation.
  always_comb begin
    look_addr = '0;
    for (int k = 0; k < FANIN; k++) begin
      if (!conn_rd_p0[k][IW])
        look_addr[(FANIN-1-k)*IN_BW +: IN_BW] = in_reg[conn_rd_p0[k][IW-1:0]*IN_BW +: IN_BW];
    end
  end

  // p0: connectivity row of neuron n (FETCH); p1: truth-table entry (LOOK)
  always_ff @(posedge clk) begin
    if (accept)
      in_reg <= io.s_data;
    if (state == FETCH)
      conn_rd_p0 <= conn_mem[n];
    if (state == LOOK)
      tbl_rd_p1 <= tbl_mem[{n, look_addr}];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      n         <= '0;
      s_ready_r <= 1'b1;
      m_valid_r <= 1'b0;
      busy_r    <= 1'b0;
      cfg_err_r <= 1'b0;
      m_data_r  <= '0;
    end else begin
      cfg_err_r <= io.cfg_we && !((state == IDLE) && cfg_in_range);
      unique case (state)
        IDLE: begin
          if (io.s_valid) begin
            state     <= FETCH;
            n         <= '0;
            s_ready_r <= 1'b0;
            busy_r    <= 1'b1;
          end
        end
        FETCH: state <= LOOK;
        LOOK:  state <= STORE;
        STORE: begin
          m_data_r[n*OUT_BW +: OUT_BW] <= tbl_rd_p1;
          if (32'(n) == NEURONS - 1) begin
            state     <= OUT;
            m_valid_r <= 1'b1;
          end else begin
            n     <= n + 1'b1;
            state <= FETCH;
          end
        end
        OUT: begin
          if (io.m_ready) begin
            state     <= IDLE;
            m_valid_r <= 1'b0;
            s_ready_r <= 1'b1;
            busy_r    <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign io.s_ready = s_ready_r;
  assign io.m_valid = m_valid_r;
  assign io.m_data  = m_data_r;
  assign io.busy    = busy_r;
  assign io.cfg_err = cfg_err_r;

`ifdef LOGICNET_LAYER_SEQ_PERF_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic [15:0] frames_q;
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frames_q <= '0;
      stall_q  <= '0;
    end else if (state == OUT) begin
      if (io.m_ready)
        frames_q <= sat_inc16(frames_q);
      else
        stall_q <= sat_inc16(stall_q);
    end
  end

  assign io.perf_frames = frames_q;
  assign io.perf_stall  = stall_q;
`else
  assign io.perf_frames = '0;
  assign io.perf_stall  = '0;
`endif
endmodule

// File: tb/tb_logicnet_layer_seq.sv
// Randomized self-checking bench for logicnet_layer_seq with a plain table-lookup reference model.
module tb_logicnet_layer_seq;
  localparam int IN_ACTS = 16;
  localparam int IN_BW   = 2;
  localparam int FANIN   = 3;
  localparam int NEURONS = 8;
  localparam int OUT_BW  = 2;
  localparam int TA      = FANIN * IN_BW;
  localparam int TSZ     = 1 << TA;
  localparam int SSPAN   = 1 << $clog2(FANIN);
  localparam int DW      = IN_ACTS * IN_BW;
  localparam int MW      = NEURONS * OUT_BW;
  localparam int LAT_EXP = 3 * NEURONS + 1;
  localparam int WAIT_MAX = 200;
`ifdef LOGICNET_LAYER_SEQ_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  int errors = 0;
  int checks = 0;

  int                conn_m [NEURONS][FANIN];
  logic [OUT_BW-1:0] tbl_m  [NEURONS][TSZ];

  logicnet_layer_seq_if #(.IN_ACTS(IN_ACTS), .IN_BW(IN_BW), .NEURONS(NEURONS), .OUT_BW(OUT_BW)) io ();

  logicnet_layer_seq #(.IN_ACTS(IN_ACTS), .IN_BW(IN_BW), .FANIN(FANIN), .NEURONS(NEURONS),
                       .OUT_BW(OUT_BW)) dut (.clk(clk), .rst_n(rst_n), .io(io));

  always #5 clk = ~clk;

  // Reference: each neuron looks up its table at the concatenation of its selected activations.
  function automatic int model_addr(input int n, input logic [DW-1:0] d);
    int addr;
    int idx;
    int a;
    logic [DW-1:0] sh;
    addr = 0;
    for (int k = 0; k < FANIN; k++) begin
      idx = conn_m[n][k];
      a = 0;
      if (idx >= 0 && idx < IN_ACTS) begin
        sh = d >> (idx * IN_BW);
        a = int'(sh[IN_BW-1:0]);
      end
      addr = addr * (1 << IN_BW) + a;
    end
    return addr;
  endfunction

  function automatic logic [MW-1:0] model_out(input logic [DW-1:0] d);
    logic [MW-1:0] r;
    r = '0;
    for (int n = 0; n < NEURONS; n++) r[n*OUT_BW +: OUT_BW] = tbl_m[n][model_addr(n, d)];
    return r;
  endfunction

  task automatic wr_tbl(input int n, input int a, input int v);
    @(negedge clk);
    io.cfg_we = 1'b1; io.cfg_sel = 1'b0;
    io.cfg_addr = 16'(n * TSZ + a); io.cfg_wdata = 16'(v);
    @(posedge clk); #1;
    io.cfg_we = 1'b0;
    tbl_m[n][a] = OUT_BW'(v);
  endtask

  task automatic wr_conn(input int n, input int s, input int idx);
    @(negedge clk);
    io.cfg_we = 1'b1; io.cfg_sel = 1'b1;
    io.cfg_addr = 16'(n * SSPAN + s); io.cfg_wdata = 16'(idx);
    @(posedge clk); #1;
    io.cfg_we = 1'b0;
    conn_m[n][s] = idx;
  endtask

  task automatic start_frame(input logic [DW-1:0] d);
    @(negedge clk);
    io.s_valid = 1'b1; io.s_data = d; io.m_ready = 1'b0;
    @(posedge clk); #1;
    io.s_valid = 1'b0;
  endtask

  task automatic wait_valid(input int k0, output int lat);
    lat = 0;
    for (int k = k0; k <= WAIT_MAX; k++) begin
      @(posedge clk); #1;
      if (io.m_valid) begin
        lat = k + 1;
        break;
      end
    end
  endtask

  task automatic deliver();
    @(negedge clk);
    io.m_ready = 1'b1;
    @(posedge clk); #1;
    io.m_ready = 1'b0;
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    checks++; if (io.s_ready !== 1'b1) begin errors++; $display("FAIL reset_s_ready: got %b want 1", io.s_ready); end
    checks++; if (io.m_valid !== 1'b0) begin errors++; $display("FAIL reset_m_valid: got %b want 0", io.m_valid); end
    checks++; if (io.m_data !== '0) begin errors++; $display("FAIL reset_m_data: got %h want 0", io.m_data); end
    checks++; if (io.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", io.busy); end
    checks++; if (io.cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err: got %b want 0", io.cfg_err); end
    checks++; if (io.perf_frames !== 16'd0 || io.perf_stall !== 16'd0) begin
      errors++; $display("FAIL reset_perf: got %0d/%0d want 0/0", io.perf_frames, io.perf_stall); end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic prog_random();
    for (int n = 0; n < NEURONS; n++)
      for (int a = 0; a < TSZ; a++) wr_tbl(n, a, int'($urandom_range(0, (1 << OUT_BW) - 1)));
    for (int n = 0; n < NEURONS; n++)
      for (int k = 0; k < FANIN; k++) wr_conn(n, k, int'($urandom_range(0, IN_ACTS - 1)));
  endtask

  task automatic test_random_frames();
    logic [DW-1:0] d;
    logic [MW-1:0] exp;
    int lat;
    for (int i = 0; i < 6; i++) begin
      d = $urandom;
      exp = model_out(d);
      start_frame(d);
      wait_valid(1, lat);
      checks++; if (lat != LAT_EXP) begin errors++; $display("FAIL rand_latency[%0d]: got %0d want %0d", i, lat, LAT_EXP); end
      checks++; if (io.m_data !== exp) begin errors++; $display("FAIL rand_data[%0d]: got %h want %h", i, io.m_data, exp); end
      deliver();
    end
  endtask

  task automatic test_identity();
    logic [DW-1:0] d;
    int lat;
    for (int n = 0; n < NEURONS; n++) begin
      for (int k = 0; k < FANIN; k++) wr_conn(n, k, k);
      for (int a = 0; a < TSZ; a++) wr_tbl(n, a, a % 4);
    end
    d = $urandom;
    d[0 +: IN_BW] = 2'd2; d[IN_BW +: IN_BW] = 2'd1; d[2*IN_BW +: IN_BW] = 2'd3;
    start_frame(d);
    wait_valid(1, lat);
    checks++; if (lat != LAT_EXP) begin errors++; $display("FAIL ident_latency: got %0d want %0d", lat, LAT_EXP); end
    checks++; if (io.m_data !== {NEURONS{2'b11}}) begin errors++; $display("FAIL ident_data: got %h want %h", io.m_data, {NEURONS{2'b11}}); end
    deliver();
  endtask

  task automatic test_addr_order();
    logic [DW-1:0] d;
    logic [MW-1:0] exp;
    int lat;
    for (int a = 0; a < TSZ; a++) wr_tbl(0, a, (a == 6'b100100) ? 1 : 0);
    wr_conn(0, 0, 5); wr_conn(0, 1, 4); wr_conn(0, 2, 3);
    for (int pass = 0; pass < 2; pass++) begin
      d = $urandom;
      d[5*IN_BW +: IN_BW] = (pass == 0) ? 2'd2 : 2'd0;
      d[4*IN_BW +: IN_BW] = 2'd1;
      d[3*IN_BW +: IN_BW] = (pass == 0) ? 2'd0 : 2'd2;
      exp = model_out(d);
      start_frame(d);
      wait_valid(1, lat);
      checks++; if (io.m_data[1:0] !== ((pass == 0) ? 2'b01 : 2'b00)) begin
        errors++; $display("FAIL order_n0[%0d]: got %b want %b", pass, io.m_data[1:0], (pass == 0) ? 2'b01 : 2'b00); end
      checks++; if (io.m_data !== exp) begin errors++; $display("FAIL order_data[%0d]: got %h want %h", pass, io.m_data, exp); end
      deliver();
    end
  endtask

  task automatic test_oor_conn();
    logic [DW-1:0] d;
    logic [MW-1:0] exp;
    logic [OUT_BW-1:0] nv;
    int a0, a4, e0, e4, lat;
    for (int a = 0; a < TSZ; a++) wr_tbl(2, a, int'($urandom_range(0, 3)));
    wr_conn(2, 0, 20); wr_conn(2, 1, 0); wr_conn(2, 2, 0);
    d = $urandom;
    d[4*IN_BW +: IN_BW] = 2'(int'($urandom_range(1, 3)));
    a0 = int'(d[0 +: IN_BW]); a4 = int'(d[4*IN_BW +: IN_BW]);
    e0 = a0 * 4 + a0; e4 = a4 * 16 + a0 * 4 + a0;
    if (tbl_m[2][e0] == tbl_m[2][e4]) begin nv = ~tbl_m[2][e0]; wr_tbl(2, e0, int'(nv)); end
    exp = model_out(d);
    start_frame(d);
    wait_valid(1, lat);
    checks++; if (io.m_data[2*OUT_BW +: OUT_BW] !== tbl_m[2][e0]) begin
      errors++; $display("FAIL oor_n2: got %b want %b", io.m_data[2*OUT_BW +: OUT_BW], tbl_m[2][e0]); end
    checks++; if (io.m_data !== exp) begin errors++; $display("FAIL oor_data: got %h want %h", io.m_data, exp); end
    deliver();
  endtask

  task automatic test_cfg_reject();
    logic [DW-1:0] d;
    logic [MW-1:0] exp;
    logic [OUT_BW-1:0] nv;
    int a0, lat;
    d = $urandom;
    exp = model_out(d);
    a0 = model_addr(0, d);
    nv = ~tbl_m[0][a0];
    start_frame(d);
    io.cfg_we = 1'b1; io.cfg_sel = 1'b0; io.cfg_addr = 16'(a0); io.cfg_wdata = 16'(nv);
    @(posedge clk); #1;
    io.cfg_we = 1'b0;
    checks++; if (io.cfg_err !== 1'b1) begin errors++; $display("FAIL busy_write_err: got %b want 1", io.cfg_err); end
    @(posedge clk); #1;
    checks++; if (io.cfg_err !== 1'b0) begin errors++; $display("FAIL busy_write_err_clear: got %b want 0", io.cfg_err); end
    wait_valid(3, lat);
    checks++; if (lat != LAT_EXP) begin errors++; $display("FAIL reject_latency: got %0d want %0d", lat, LAT_EXP); end
    checks++; if (io.m_data !== exp) begin errors++; $display("FAIL reject_table_kept: got %h want %h", io.m_data, exp); end
    deliver();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      io.cfg_we = 1'b1; io.cfg_sel = (c == 1);
      io.cfg_addr = (c == 0) ? 16'(NEURONS * TSZ) : 16'(FANIN); io.cfg_wdata = 16'd0;
      @(posedge clk); #1;
      io.cfg_we = 1'b0;
      checks++; if (io.cfg_err !== 1'b1) begin errors++; $display("FAIL range_err[%0d]: got %b want 1", c, io.cfg_err); end
      @(posedge clk); #1;
      checks++; if (io.cfg_err !== 1'b0) begin errors++; $display("FAIL range_err_clear[%0d]: got %b want 0", c, io.cfg_err); end
    end
    wr_tbl(NEURONS - 1, TSZ - 1, int'($urandom_range(0, 3)));
    checks++; if (io.cfg_err !== 1'b0) begin errors++; $display("FAIL good_write_err: got %b want 0", io.cfg_err); end
  endtask

  task automatic test_same_cycle_cfg();
    logic [DW-1:0] d;
    logic [MW-1:0] exp;
    logic [OUT_BW-1:0] nv;
    int a0, lat;
    d = $urandom;
    a0 = model_addr(0, d);
    nv = ~tbl_m[0][a0];
    @(negedge clk);
    io.s_valid = 1'b1; io.s_data = d;
    io.cfg_we = 1'b1; io.cfg_sel = 1'b0; io.cfg_addr = 16'(a0); io.cfg_wdata = 16'(nv);
    @(posedge clk); #1;
    io.s_valid = 1'b0; io.cfg_we = 1'b0;
    tbl_m[0][a0] = nv;
    exp = model_out(d);
    checks++; if (io.cfg_err !== 1'b0) begin errors++; $display("FAIL same_cycle_err: got %b want 0", io.cfg_err); end
    wait_valid(1, lat);
    checks++; if (io.m_data !== exp) begin errors++; $display("FAIL same_cycle_data: got %h want %h", io.m_data, exp); end
    deliver();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d;
    logic [MW-1:0] exp;
    int lat;
    d = $urandom;
    start_frame(d);
    checks++; if (io.busy !== 1'b1 || io.s_ready !== 1'b0) begin
      errors++; $display("FAIL frame_busy: got busy=%b s_ready=%b want 1/0", io.busy, io.s_ready); end
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    checks++; if (io.s_ready !== 1'b1) begin errors++; $display("FAIL mid_s_ready: got %b want 1", io.s_ready); end
    checks++; if (io.m_valid !== 1'b0) begin errors++; $display("FAIL mid_m_valid: got %b want 0", io.m_valid); end
    checks++; if (io.m_data !== '0) begin errors++; $display("FAIL mid_m_data: got %h want 0", io.m_data); end
    checks++; if (io.busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b want 0", io.busy); end
    checks++; if (io.perf_frames !== 16'd0) begin errors++; $display("FAIL mid_perf_frames: got %0d want 0", io.perf_frames); end
    @(negedge clk) rst_n = 1'b1;
    d = $urandom;
    exp = model_out(d);
    start_frame(d);
    wait_valid(1, lat);
    checks++; if (lat != LAT_EXP) begin errors++; $display("FAIL post_reset_latency: got %0d want %0d", lat, LAT_EXP); end
    checks++; if (io.m_data !== exp) begin errors++; $display("FAIL post_reset_data: got %h want %h", io.m_data, exp); end
    deliver();
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] d;
    logic [MW-1:0] exp;
    int lat;
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk) rst_n = 1'b1;
    d = $urandom;
    exp = model_out(d);
    start_frame(d);
    wait_valid(1, lat);
    checks++; if (io.m_data !== exp) begin errors++; $display("FAIL bp_data: got %h want %h", io.m_data, exp); end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      checks++; if (io.m_valid !== 1'b1 || io.s_ready !== 1'b0 || io.m_data !== exp) begin
        errors++; $display("FAIL bp_hold[%0d]: got v=%b r=%b d=%h want 1/0/%h", i, io.m_valid, io.s_ready, io.m_data, exp); end
    end
    checks++; if (io.perf_stall !== (PERF ? 16'd10 : 16'd0)) begin
      errors++; $display("FAIL bp_stall: got %0d want %0d", io.perf_stall, PERF ? 10 : 0); end
    deliver();
    checks++; if (io.m_valid !== 1'b0 || io.s_ready !== 1'b1 || io.busy !== 1'b0) begin
      errors++; $display("FAIL bp_idle: got v=%b r=%b busy=%b want 0/1/0", io.m_valid, io.s_ready, io.busy); end
    checks++; if (io.perf_frames !== (PERF ? 16'd1 : 16'd0)) begin
      errors++; $display("FAIL bp_frames: got %0d want %0d", io.perf_frames, PERF ? 1 : 0); end
    checks++; if (io.m_data !== exp) begin errors++; $display("FAIL bp_retain: got %h want %h", io.m_data, exp); end
  endtask

  initial begin
    io.cfg_we = 1'b0; io.cfg_sel = 1'b0; io.cfg_addr = '0; io.cfg_wdata = '0;
    io.s_valid = 1'b0; io.s_data = '0; io.m_ready = 1'b0;
    test_reset();
    prog_random();
    test_random_frames();
    test_identity();
    test_addr_order();
    test_oor_conn();
    test_cfg_reject();
    test_same_cycle_cfg();
    test_reset_mid();
    test_backpressure();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
